right_shift_pipe: RTL and testbench

// - Generic pipelined right shifter: the return path paired with the combinational left shifter.
// - Accepts a width-bit word and a shift amount over a valid/ready stream.
// - Produces the word shifted right after a fixed pipeline latency.
// - Sits between stream producers/consumers in datapaths where a full-width barrel shift
//   in one cycle misses timing.

---
 rtl/right_shift_pipe.sv | 118 +++++++++++
 tb/tb_right_shift_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/right_shift_pipe.sv
// right_shift_pipe: pipelined right shifter on a valid/ready stream.
// Stage k shifts right by 2^k when shift bit k is set. Output appears SW cycles
// after acceptance when the output side does not stall. The whole pipe advances
// together, and only when the output register is empty or being drained.
//
// Optional feature: define RIGHT_SHIFT_PIPE_ARITH_EN to add the arith input.
// arith=1 fills vacated bits with the word's MSB.
//
// Ports
//   clk     in   1      clock
//   rst_n   in   1      asynchronous active-low reset
//   iValid  in   1      input word valid
//   iReady  out  1      pipe can accept a word this cycle
//   iBits   in   width  input word
//   shift   in   SW     right shift amount, 0..width-1
//   arith   in   1      (RIGHT_SHIFT_PIPE_ARITH_EN only) 1 = sign fill
//   oValid  out  1      output word valid
//   oReady  in   1      downstream takes the output this cycle
//   oBits   out  width  shifted word
module right_shift_pipe #(
    parameter int width = 8,
    localparam int SW = $clog2(width)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iValid,
    output logic             iReady,
    input  logic [width-1:0] iBits,
    input  logic [SW-1:0]    shift,
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
    input  logic             arith,
`endif
    output logic             oValid,
    input  logic             oReady,
    output logic [width-1:0] oBits
);

    logic [width-1:0] data_q [SW];
    logic [SW-1:0]    sh_q   [SW];
    logic [SW-1:0]    vld_q;

    logic [width-1:0] d_in  [SW];
    logic [SW-1:0]    s_in  [SW];
    logic [SW-1:0]    v_in;
    logic [width-1:0] d_nxt [SW];
    logic             adv;
    logic             fill;

`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
    logic [SW-1:0]    arith_q;
    logic [SW-1:0]    a_in;
`endif

    assign adv    = !vld_q[SW-1] || oReady;
    assign iReady = adv;
    assign oValid = vld_q[SW-1];
    assign oBits  = data_q[SW-1];

    // Stage inputs: stage 0 reads the port, later stages read the previous register.
    always_comb begin
        d_in[0] = iBits;
        s_in[0] = shift;
        v_in[0] = iValid;
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
        a_in[0] = arith;
`endif
        for (int k = 1; k < SW; k++) begin
            d_in[k] = data_q[k-1];
            s_in[k] = sh_q[k-1];
            v_in[k] = vld_q[k-1];
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
            a_in[k] = arith_q[k-1];
`endif
        end
    end

    // An arithmetic shift never changes the MSB, so every stage still sees the
    // original sign bit at width-1. Sign fill is done as ~(~x >> n).
    always_comb begin
        fill = 1'b0;
        for (int k = 0; k < SW; k++) begin
            fill     = 1'b0;
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
            fill     = a_in[k] && d_in[k][width-1];
`endif
            d_nxt[k] = d_in[k];
            if (s_in[k][k]) begin
                if (fill)
                    d_nxt[k] = ~((~d_in[k]) >> (1 << k));
                else
                    d_nxt[k] = d_in[k] >> (1 << k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < SW; k++) begin
                data_q[k] <= '0;
                sh_q[k]   <= '0;
            end
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
            arith_q <= '0;
`endif
        end else if (adv) begin
            vld_q <= v_in;
            for (int k = 0; k < SW; k++) begin
                data_q[k] <= d_nxt[k];
                sh_q[k]   <= s_in[k];
            end
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
            arith_q <= a_in;
`endif
        end
    end

endmodule

// File: tb/tb_right_shift_pipe.sv
// Scoreboard bench for right_shift_pipe at width=8.
// Inputs are driven at the falling edge. The monitor samples 1 ns before the
// rising edge: it records accepted inputs, pops and checks delivered outputs, and
// checks iReady and output hold under stall.
module tb_right_shift_pipe;

    localparam int W   = 8;
    localparam int SWL = 3;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           iValid = 1'b0;
    logic           iReady;
    logic [W-1:0]   iBits = '0;
    logic [SWL-1:0] shift = '0;
    logic           arith = 1'b0;
    logic           oValid;
    logic           oReady = 1'b0;
    logic [W-1:0]   oBits;

    typedef struct {
        logic [W-1:0] d;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t sb[$];

    int     n_vec = 0;
    int     n_err = 0;
    int     cyc = 0;
    bit     acc_flag = 1'b0;
    bit     lat_mode = 1'b0;
    bit     prev_stall = 1'b0;
    logic [W-1:0] prev_bits = '0;

    always #5 clk = ~clk;

    right_shift_pipe #(.width(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iValid (iValid),
        .iReady (iReady),
        .iBits  (iBits),
        .shift  (shift),
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
        .arith  (arith),
`endif
        .oValid (oValid),
        .oReady (oReady),
        .oBits  (oBits)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input bit a);
        logic [W-1:0] r;
        r = d >> s;
        if (a && d[W-1])
            for (int i = W - s; i < W; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Monitor: 1 ns before each rising edge.
    always @(negedge clk) begin
        exp_t e;
        #4;
        cyc++;
        acc_flag = 1'b0;
        if (rst_n) begin
            chk("iready_rule", iReady, !oValid || oReady);
            if (prev_stall && oValid)
                chk("hold_bits", oBits, prev_bits);
            if (iValid && iReady) begin
                acc_flag = 1'b1;
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
                sb.push_back('{model(iBits, int'(shift), arith), cyc, lat_mode});
`else
                sb.push_back('{model(iBits, int'(shift), 1'b0), cyc, lat_mode});
`endif
            end
            if (oValid && oReady) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("obits", oBits, e.d);
                    if (e.lat) chk("latency", cyc - e.cyc, LAT);
                end
            end
            prev_stall = oValid && !oReady;
            prev_bits  = oBits;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] d, input int s, input bit a);
        int n;
        n = 0;
        @(negedge clk);
        iValid = 1'b1;
        iBits  = d;
        shift  = SWL'(s);
        arith  = a;
        forever begin
            @(posedge clk);
            if (acc_flag) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", n, 0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        iValid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    bit rand_rdy = 1'b0;

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ovalid", oValid, 0);
        chk("rst_obits", oBits, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_iready", iReady, 1);

        // Basic shift with latency
        oReady   = 1'b1;
        lat_mode = 1'b1;
        send(8'hB4, 2, 1'b0);
        idle(6);
        drain();

        // Streaming: 8'hFF shifted by 0..7, back to back
        for (int s = 0; s < 8; s++) send(8'hFF, s, 1'b0);
        idle(6);
        drain();

        // Boundaries on a different pattern
        send(8'hA5, 0, 1'b0);
        send(8'h80, 7, 1'b0);
        send(8'h7F, 7, 1'b0);
        idle(6);
        drain();
        lat_mode = 1'b0;

        // Backpressure: fill the pipe while output is blocked
        oReady = 1'b0;
        send(8'hC3, 1, 1'b0);
        send(8'h3C, 2, 1'b0);
        send(8'h96, 4, 1'b0);
        @(negedge clk);
        iValid = 1'b1;
        iBits  = 8'h5A;
        shift  = 3'd3;
        repeat (4) @(negedge clk);
        #1;
        chk("bp_iready", iReady, 0);
        chk("bp_ovalid", oValid, 1);
        chk("bp_count", sb.size(), 3);
        oReady = 1'b1;
        repeat (20) begin
            @(posedge clk);
            if (acc_flag) break;
        end
        idle(6);
        drain();

        // Random words with random output stalls
        fork
            begin
                for (int i = 0; i < 40; i++)
`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
                    send(W'($urandom), $urandom_range(0, 7), 1'($urandom));
`else
                    send(W'($urandom), $urandom_range(0, 7), 1'b0);
`endif
                rand_rdy = 1'b1;
            end
            begin
                while (!rand_rdy) begin
                    @(negedge clk);
                    oReady = 1'($urandom_range(0, 1));
                end
            end
        join
        rand_rdy = 1'b0;
        @(negedge clk);
        oReady = 1'b1;
        idle(2);
        drain();

`ifdef RIGHT_SHIFT_PIPE_ARITH_EN
        // Arithmetic fill
        lat_mode = 1'b1;
        send(8'h90, 3, 1'b1);
        send(8'h90, 3, 1'b0);
        send(8'h80, 7, 1'b1);
        send(8'h70, 2, 1'b1);
        idle(6);
        drain();
        lat_mode = 1'b0;
`endif

        // Mid-stream reset with three words in flight
        oReady = 1'b0;
        send(8'h11, 0, 1'b0);
        send(8'h22, 1, 1'b0);
        send(8'h44, 2, 1'b0);
        @(negedge clk);
        iValid = 1'b0;
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_ovalid", oValid, 0);
        chk("midrst_obits", oBits, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        oReady = 1'b1;
        idle(8);
        chk("midrst_nostale", sb.size(), 0);

        // Pipe still works after reset
        lat_mode = 1'b1;
        send(8'hF0, 4, 1'b0);
        idle(6);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL global_timeout: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

endmodule
